// File: rtl/buzzer_melodia_pkg.sv
// buzzer_pkg: note codes, frequency table, FSM states and melody table for the buzzer sequencer
package buzzer_pkg;
  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] C5   = 4'd1;
  localparam logic [3:0] D5   = 4'd2;
  localparam logic [3:0] E5   = 4'd3;
  localparam logic [3:0] F5   = 4'd4;
  localparam logic [3:0] G5   = 4'd5;
  localparam logic [3:0] A5   = 4'd6;
  localparam logic [3:0] B5   = 4'd7;
  localparam logic [3:0] C6   = 4'd8;
  localparam logic [3:0] END  = 4'd15;
  localparam int unsigned FREQ_HZ [8] = '{523, 587, 659, 698, 784, 880, 988, 1047};
  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;
  localparam logic [3:0] MELODIAS [4][8] = '{
    '{C5, E5, G5, C6, END, END, END, END},
    '{G5, REST, G5, REST, G5, END, END, END},
    '{C6, A5, F5, D5, C5, END, END, END},
    '{A5, REST, A5, REST, A5, REST, A5, REST}
  };
  // Codes outside C5..C6 (rest, 9..14, END) yield 0, which the sequencer plays as silence.
  function automatic int unsigned half_period(int unsigned clk_freq, logic [3:0] code);
    return (code >= C5 && code <= C6) ? clk_freq / (2 * FREQ_HZ[3'(code - C5)]) : 0;
  endfunction
endpackage

// File: rtl/buzzer_melodia_if.sv
// buzzer_melodia_if: request/status bundle between the game FSM and the buzzer sequencer
interface buzzer_melodia_if;
  logic       play;
  logic [1:0] melodia_sel;
  logic       stop;
  logic       buzzer;
  logic       busy;
  logic       done;
  modport master (output play, melodia_sel, stop, input buzzer, busy, done);
  modport slave  (input play, melodia_sel, stop, output buzzer, busy, done);
endinterface

// File: rtl/buzzer_melodia_rom.sv
// melodia_rom: combinational lookup of a melody slot's note code and tone half-period
module melodia_rom
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int          HP_W     = 17
) (
  input  logic [1:0]      melodia_sel,
  input  logic [2:0]      step,
  output logic [3:0]      code,
  output logic [HP_W-1:0] hp
);
  logic [HP_W-1:0] hp_tab [16];
  for (genvar i = 0; i < 16; i++) begin : g_hp
    assign hp_tab[i] = HP_W'(half_period(CLK_FREQ, 4'(i)));
  end
  assign code = MELODIAS[melodia_sel][step];
  assign hp   = hp_tab[code];
endmodule

// File: rtl/buzzer_melodia.sv
// buzzer_melodia: melody sequencer driving the piezo with timed square-wave notes and gaps
module buzzer_melodia
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned STEP_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES  = 500_000,
  parameter int          HP_W        = 17
) (
  input logic clk,
  input logic rst_n,
  buzzer_melodia_if.slave bus
);
  localparam int unsigned CNT_MAX = STEP_CYCLES > GAP_CYCLES ? STEP_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
  state_t state;
  logic [1:0] sel;
  logic [2:0] step, idx;
  logic [CNT_W-1:0] cnt;
  logic [HP_W-1:0] hp_cnt, hp;
  logic [3:0] code;
  logic note_last, adv, fin, empty, tick;
  // While a step is ending the ROM already looks at the next slot, so an end marker costs no cycles.
  assign note_last = state == NOTE && cnt == STEP_LAST;
  assign adv = (note_last && GAP_CYCLES == 0) || (state == GAP && cnt == GAP_LAST);
  assign idx = (state == GAP || note_last) ? step + 3'd1 : step;
  assign fin = step == 3'd7 || code == END;
  assign empty = MELODIAS[bus.melodia_sel][0] == END;
  assign tick = hp != '0 && hp_cnt == hp - 1'b1;
  melodia_rom #(.CLK_FREQ(CLK_FREQ), .HP_W(HP_W)) u_rom (
    .melodia_sel(sel),
    .step(idx),
    .code(code),
    .hp(hp)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      step <= '0;
      cnt <= '0;
      hp_cnt <= '0;
      bus.buzzer <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.play) begin
          sel <= bus.melodia_sel;
          // An empty melody parks on the last gap cycle of slot 7 so it finishes one cycle later.
          step <= empty ? 3'd7 : 3'd0;
          cnt <= empty ? GAP_LAST : '0;
          hp_cnt <= '0;
          bus.buzzer <= 1'b0;
          bus.busy <= 1'b1;
          state <= empty ? GAP : NOTE;
        end
        NOTE: begin
          cnt <= note_last ? '0 : cnt + 1'b1;
          hp_cnt <= hp_cnt == hp - 1'b1 ? '0 : hp_cnt + 1'b1;
          bus.buzzer <= note_last ? 1'b0 : tick ^ bus.buzzer;
          if (note_last) state <= GAP;
        end
        GAP: cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
      if (adv) begin
        if (fin) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else begin
          state <= NOTE;
          step <= step + 3'd1;
          cnt <= '0;
          hp_cnt <= '0;
        end
      end
      if (bus.stop) begin
        state <= IDLE;
        bus.buzzer <= 1'b0;
        bus.busy <= 1'b0;
        bus.done <= 1'b0;
      end
    end
  end
endmodule
